serial_alu_ctrl: RTL and testbench

SERIAL_ALU_CTRL -- requirements
Module: serial_alu_ctrl

---
 rtl/serial_alu_ctrl_pkg.sv | 14 +
 rtl/alu_bit_slice.sv | 16 +
 rtl/serial_alu_ctrl.sv | 93 +++++++++
 tb/tb_serial_alu_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_alu_ctrl_pkg.sv
// serial_alu_ctrl_pkg: op encodings and FSM state type shared by the serial ALU
package serial_alu_ctrl_pkg;
    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_ADD = 2'b01,
        OP_OR  = 2'b10,
        OP_XOR = 2'b11
    } op_e;
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;
endpackage

// File: rtl/alu_bit_slice.sv
// alu_bit_slice: one-bit AND/ADD/OR/XOR with carry, selected by op
module alu_bit_slice
    import serial_alu_ctrl_pkg::*;
(
    input  op_e  op_i,
    input  logic a_i,
    input  logic b_i,
    input  logic carry_i,
    output logic sum_o,
    output logic carry_o
);
    assign sum_o   = op_i == OP_AND ? a_i & b_i :
                     op_i == OP_ADD ? a_i ^ b_i ^ carry_i :
                     op_i == OP_OR  ? a_i | b_i : a_i ^ b_i;
    assign carry_o = op_i == OP_ADD && ((a_i & b_i) | (carry_i & (a_i ^ b_i)));
endmodule

// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl: bit-serial ALU, one operand bit per clock LSB-first, valid/ready on both sides
module serial_alu_ctrl
    import serial_alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero
);
    localparam int IW = $clog2(WIDTH);
    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             s_bit, s_carry;

    alu_bit_slice u_slice (
        .op_i    (op_q),
        .a_i     (a_q[idx_q]),
        .b_i     (b_q[idx_q]),
        .carry_i (carry_q),
        .sum_o   (s_bit),
        .carry_o (s_carry)
    );

    // next state: latch request in IDLE, shift one slice bit per cycle in RUN, wait for consumer in DONE
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        case (state_q)
            S_IDLE: if (in_valid) begin
                op_d    = op_e'(op);
                a_d     = a;
                b_d     = b;
                res_d   = '0;
                idx_d   = '0;
                carry_d = 1'b0;
                state_d = S_RUN;
            end
            S_RUN: begin
                res_d   = {s_bit, res_q[WIDTH-1:1]};
                carry_d = op_q == OP_ADD && s_carry;
                idx_d   = idx_q + IW'(1);
                state_d = idx_q == IW'(WIDTH - 1) ? S_DONE : S_RUN;
            end
            S_DONE: state_d = out_ready ? S_IDLE : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // state and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_AND;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
        end
    end

    assign in_ready  = state_q == S_IDLE;
    assign out_valid = state_q == S_DONE;
    assign result    = res_q;
    assign carry_out = carry_q;
    assign zero      = out_valid && res_q == '0;
endmodule

// File: tb/tb_serial_alu_ctrl.sv
// tb_serial_alu_ctrl: table-driven and scoreboard checks of the serial ALU at WIDTH=8
module tb_serial_alu_ctrl;
    localparam int W = 8;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         carry_out;
    logic         zero;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         c;
        logic         z;
    } vec_t;
    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         z;
    } exp_t;

    vec_t tbl[12];
    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .zero      (zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.res = v.res;
        e.c   = v.c;
        e.z   = v.z;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input string nm);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got result with empty scoreboard want queued entry", nm);
        end else begin
            e = sb.pop_front();
            chk({nm, "_result"}, 32'(result), 32'(e.res));
            chk({nm, "_carry"}, 32'(carry_out), 32'(e.c));
            chk({nm, "_zero"}, 32'(zero), 32'(e.z));
        end
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic do_req(input vec_t v, input int hold, input bit glitch);
        int  n;
        bit  seen;
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        op = v.op;
        a = v.a;
        b = v.b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        push_exp(v);
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            if (glitch && n == 2) begin
                in_valid = 1'b1;
                a = 8'h11;
                op = 2'b11;
            end else if (glitch && n == 3) begin
                in_valid = 1'b0;
            end
            if (n == 3) chk("run_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", 32'(n), 32'(W));
        pop_chk("vec");
        chk("done_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_result", 32'(result), 32'(v.res));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("leave_valid", 32'(out_valid), 32'd0);
        chk("leave_zero", 32'(zero), 32'd0);
        chk("leave_in_ready", 32'(in_ready), 32'd1);
        if (glitch) begin
            seen = 1'b0;
            for (int i = 0; i < 12; i++) begin
                @(posedge clk);
                #1;
                if (out_valid === 1'b1) seen = 1'b1;
            end
            chk("ignored_req_no_output", 32'(seen), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   acc[4];
        bit   seen;
        vec_t v;
        tbl[0]  = '{2'b01, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
        tbl[1]  = '{2'b11, 8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0};
        tbl[2]  = '{2'b00, 8'hA5, 8'h5A, 8'h00, 1'b0, 1'b1};
        tbl[3]  = '{2'b10, 8'h30, 8'h03, 8'h33, 1'b0, 1'b0};
        tbl[4]  = '{2'b01, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0};
        tbl[5]  = '{2'b01, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0};
        tbl[6]  = '{2'b01, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        tbl[7]  = '{2'b01, 8'hC8, 8'h64, 8'h2C, 1'b1, 1'b0};
        tbl[8]  = '{2'b11, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1};
        tbl[9]  = '{2'b10, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
        tbl[10] = '{2'b00, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
        tbl[11] = '{2'b01, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0};

        #3;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_carry", 32'(carry_out), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        #9;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) do_req(tbl[i], i == 3 ? 5 : 0, i == 4);

        op = 2'b01;
        a = 8'h7F;
        b = 8'h01;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_abort_carry", 32'(carry_out), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_carry", 32'(carry_out), 32'd0);
        chk("abort_zero", 32'(zero), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        chk("abort_no_output", 32'(seen), 32'd0);
        do_req(tbl[11], 0, 1'b0);

        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            v = tbl[k + 4];
            op = v.op;
            a = v.a;
            b = v.b;
            n = 0;
            while (in_ready !== 1'b1 && n < 40) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("b2b_wait_ready", 32'(n < 40), 32'd1);
            @(posedge clk);
            #1;
            acc[k] = cyc;
            push_exp(v);
            wait_out(n);
            chk("b2b_latency", 32'(n), 32'(W));
            pop_chk("b2b");
            if (k > 0) chk("b2b_period", 32'(acc[k] - acc[k-1]), 32'(W + 2));
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("b2b_end_in_ready", 32'(in_ready), 32'd1);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
